// File: rtl/rejunity_snn_core_pkg.sv
// Shared sizes, reset values and mode encodings for the single-layer LIF spiking core.
package rejunity_snn_core_pkg;

  localparam int N_IN       = 8;
  localparam int N_NEURONS  = 8;
  localparam int U_WIDTH    = 8;
  localparam int W_BITS     = N_IN * N_NEURONS;
  localparam logic [U_WIDTH-1:0] THRESH_RST = 8'd5;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_WLOAD  = 2'b01,
    MODE_THRESH = 2'b10,
    MODE_LEAK   = 2'b11
  } mode_e;

  typedef logic [U_WIDTH-1:0] membrane_t;

endpackage

// File: rtl/rejunity_snn_core_neuron.sv
// One leaky integrate-and-fire neuron: signed synapse sum, shift leak, clamp and threshold compare.
// Purely combinational; the membrane register lives in the top so all state shares one reset/enable.
module snn_lif_neuron
  import rejunity_snn_core_pkg::*;
(
  input  logic [N_IN-1:0]    spikes_i,
  input  logic [N_IN-1:0]    weights_i,
  input  logic [U_WIDTH-1:0] thresh_i,
  input  logic [2:0]         shift_i,
  input  logic               run_i,
  input  membrane_t          u_i,
  output logic               spike_o,
  output membrane_t          u_o
);

  logic signed [4:0] sum;
  membrane_t         leaked;
  logic signed [9:0] acc;
  membrane_t         acc_c;
  logic              fire;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spikes_i[i]) begin
        sum = weights_i[i] ? (sum + 5'sd1) : (sum - 5'sd1);
      end
    end

    leaked = (shift_i == 3'd0) ? u_i : (u_i - (u_i >> shift_i));
    acc    = $signed({2'b00, leaked}) + $signed({{5{sum[4]}}, sum});

    // acc spans -8..263, so bit 9 flags negative and bit 8 flags overflow
    if (acc[9]) begin
      acc_c = '0;
    end else if (acc[8]) begin
      acc_c = '1;
    end else begin
      acc_c = acc[7:0];
    end

    fire    = (acc_c >= thresh_i);
    spike_o = run_i & fire;
    if (!run_i) begin
      u_o = u_i;
    end else if (fire) begin
      u_o = '0;
    end else begin
      u_o = acc_c;
    end
  end

endmodule

// File: rtl/rejunity_snn_core.sv
// 8-input / 8-neuron spiking core with serial weight load, threshold and leak-shift
// configuration multiplexed onto the spike input pins.
module rejunity_snn_core
  import rejunity_snn_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [W_BITS-1:0]                w_q;
  logic [U_WIDTH-1:0]               thresh_q;
  logic [2:0]                       shift_q;
  logic [N_NEURONS-1:0]             uo_q;
  membrane_t [N_NEURONS-1:0]        u_q;
  membrane_t [N_NEURONS-1:0]        u_d;
  logic [N_NEURONS-1:0]             spike_d;
  mode_e                            mode;
  logic                             run;
  logic                             unused_uio;

  assign mode       = mode_e'(uio_in[1:0]);
  assign run        = (mode == MODE_RUN);
  assign unused_uio = &{1'b0, uio_in[7:3]};

  for (genvar j = 0; j < N_NEURONS; j++) begin : g_neuron
    snn_lif_neuron u_lif (
      .spikes_i  (ui_in),
      .weights_i (w_q[j*N_IN +: N_IN]),
      .thresh_i  (thresh_q),
      .shift_i   (shift_q),
      .run_i     (run),
      .u_i       (u_q[j]),
      .spike_o   (spike_d[j]),
      .u_o       (u_d[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= '1;
      thresh_q <= THRESH_RST;
      shift_q  <= '0;
      uo_q     <= '0;
      u_q      <= '0;
    end else if (ena) begin
      case (mode)
        MODE_WLOAD:  w_q      <= {w_q[W_BITS-2:0], uio_in[2]};
        MODE_THRESH: thresh_q <= ui_in;
        MODE_LEAK:   shift_q  <= ui_in[2:0];
        default:     ;
      endcase
      // neurons report no spike and pass u through unchanged outside RUN
      uo_q <= spike_d;
      u_q  <= u_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_rejunity_snn_core.sv
// Self-checking bench: directed vector table, hand sequences, then random traffic against a model.
module tb_rejunity_snn_core;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  rejunity_snn_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic straight from the neuron rules.
  int         m_w [8][8];   // m_w[j][i] = +1 or -1
  int         m_u [8];
  int         m_thr;
  int         m_s;
  logic [7:0] m_uo;

  task automatic model_reset();
    for (int j = 0; j < 8; j++) begin
      m_u[j] = 0;
      for (int i = 0; i < 8; i++) m_w[j][i] = 1;
    end
    m_thr = 5;
    m_s   = 0;
    m_uo  = 8'h00;
  endtask

  task automatic model_step(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    int sum, lk, acc, flat_prev [64], flat [64];
    if (r) begin
      model_reset();
    end else if (e) begin
      case (uio[1:0])
        2'b00: begin
          for (int j = 0; j < 8; j++) begin
            sum = 0;
            for (int i = 0; i < 8; i++) if (ui[i]) sum += m_w[j][i];
            lk  = (m_s == 0) ? m_u[j] : m_u[j] - (m_u[j] / (1 << m_s));
            acc = lk + sum;
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            if (acc >= m_thr) begin
              m_uo[j] = 1'b1;
              m_u[j]  = 0;
            end else begin
              m_uo[j] = 1'b0;
              m_u[j]  = acc;
            end
          end
        end
        2'b01: begin
          // flat index k = j*8+i; new bit enters at k=0, everything moves up one
          for (int k = 0; k < 64; k++) flat_prev[k] = m_w[k / 8][k % 8];
          flat[0] = uio[2] ? 1 : -1;
          for (int k = 1; k < 64; k++) flat[k] = flat_prev[k-1];
          for (int k = 0; k < 64; k++) m_w[k / 8][k % 8] = flat[k];
          m_uo = 8'h00;
        end
        2'b10: begin
          m_thr = int'(ui);
          m_uo  = 8'h00;
        end
        default: begin
          m_s  = int'(ui[2:0]);
          m_uo = 8'h00;
        end
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("uo_vs_model", int'(uo_out), int'(m_uo));
    check("uio_out", int'(uio_out), 0);
    check("uio_oe", int'(uio_oe), 0);
    for (int j = 0; j < 8; j++) check($sformatf("u%0d_vs_model", j), int'(dut.u_q[j]), m_u[j]);
  endtask

  task automatic cycle(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    rst    = r;
    ena    = e;
    ui_in  = ui;
    uio_in = uio;
    @(posedge clk);
    #1;
    model_step(r, e, ui, uio);
    check_model();
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] exp_u0;
  } vec_t;

  vec_t tbl [21];

  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();

    tbl[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd2};
    tbl[5]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd4};
    tbl[6]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hFF, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd2};
    tbl[8]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd4};
    tbl[9]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hFF, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 8'h01, 8'h03, 8'h00, 8'd0};  // leak s=1
    tbl[11] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd2};
    tbl[12] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd3};
    tbl[13] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd4};
    tbl[14] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'd4};
    tbl[15] = '{1'b0, 1'b1, 8'h04, 8'h02, 8'h00, 8'd4};  // threshold 4
    tbl[16] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hFF, 8'd0};
    tbl[17] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'd0};  // frozen
    tbl[18] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'hFF, 8'd0};  // frozen WLOAD of a 0
    tbl[19] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'd0};
    tbl[20] = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'd1};  // W[0] still +1

    for (int k = 0; k < 21; k++) begin
      cycle(tbl[k].r, tbl[k].e, tbl[k].ui, tbl[k].uio);
      check($sformatf("tbl%0d_uo", k), int'(uo_out), int'(tbl[k].exp_uo));
      check($sformatf("tbl%0d_u0", k), int'(dut.u_q[0]), int'(tbl[k].exp_u0));
    end

    // five frozen cycles with spikes present
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 8'hFF, 8'h00);
      check("freeze_u0", int'(dut.u_q[0]), 1);
      check("freeze_uo", int'(uo_out), 0);
    end

    // first shifted bit must land on neuron 7 / input 7
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 8'h05);
    for (int k = 0; k < 63; k++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    cycle(1'b0, 1'b1, 8'h01, 8'h02);
    cycle(1'b0, 1'b1, 8'h80, 8'h00);
    check("worder_uo", int'(uo_out), 8'h80);

    // all weights -1: potentials pinned at 0
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 64; k++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 8'hFF, 8'h00);
      check("neg_uo", int'(uo_out), 0);
      check("neg_u7", int'(dut.u_q[7]), 0);
    end

    // reset mid-load restores all +1 weights
    cycle(1'b1, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'h00, 8'h01);
    cycle(1'b1, 1'b1, 8'h00, 8'h01);
    cycle(1'b0, 1'b1, 8'hFF, 8'h00);
    check("midload_rst_uo", int'(uo_out), 8'hFF);

    // threshold 0 fires with no input
    cycle(1'b0, 1'b1, 8'h00, 8'h02);
    check("thr0_cfg_uo", int'(uo_out), 0);
    cycle(1'b0, 1'b1, 8'h00, 8'h00);
    check("thr0_uo", int'(uo_out), 8'hFF);

    // reset wins over ena=0
    cycle(1'b0, 1'b1, 8'h06, 8'h02);
    cycle(1'b0, 1'b1, 8'h03, 8'h00);
    check("pre_rst_u0", int'(dut.u_q[0]), 2);
    cycle(1'b1, 1'b0, 8'h03, 8'h00);
    check("rst_noena_u0", int'(dut.u_q[0]), 0);

    for (int k = 0; k < 600; k++) begin
      logic       r, e;
      logic [7:0] ui, uio;
      int         pick;
      r    = ($urandom_range(0, 99) < 2);
      e    = ($urandom_range(0, 9) != 0);
      ui   = 8'($urandom);
      pick = $urandom_range(0, 19);
      uio  = {5'($urandom), 1'($urandom), 2'b00};
      if (pick < 3) uio[1:0] = 2'b01;
      else if (pick == 3) begin
        uio[1:0] = 2'b10;
        ui = 8'($urandom_range(0, 24));
      end else if (pick == 4) uio[1:0] = 2'b11;
      cycle(r, e, ui, uio);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
